// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch types and widths
package riscv_pkg;

    localparam int ADDRSZ  = 64;
    localparam int INSTRSZ = 32;
    localparam int LINESZ  = 64;

    localparam logic [INSTRSZ-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch bundle: memory line port, decoder port, redirect
interface instr_fetch_if;
    import riscv_pkg::*;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDRSZ-1:0]  mem_req_addr;
    logic               mem_resp_valid;
    logic [LINESZ-1:0]  mem_resp_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTRSZ-1:0] instr;
    logic [ADDRSZ-1:0]  instr_pc;
    logic               redirect_valid;
    logic [ADDRSZ-1:0]  redirect_pc;

    modport master (
        output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
        output mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_line_buf.sv
// rtl/fetch_line_buf.sv - holds one fetched line and selects the active half
module fetch_line_buf
    import riscv_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [LINESZ-1:0]  line_in,
    input  logic               sel,
    output logic [INSTRSZ-1:0] word
);

    logic [LINESZ-1:0] line_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= line_in;
        end
    end

    assign word = sel ? line_q[LINESZ-1:INSTRSZ] : line_q[INSTRSZ-1:0];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner: fetches 64-bit lines, feeds decoder one word per cycle
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [ADDRSZ-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    fetch_state_t       state, state_nxt;
    logic [ADDRSZ-1:0]  pc, pc_nxt;
    logic               squash, squash_nxt;
    logic               slot, slot_nxt;
    logic               line_load;
    logic [INSTRSZ-1:0] slot_word;

    fetch_line_buf u_line_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (line_load),
        .line_in (bus.mem_resp_data),
        .sel     (slot),
        .word    (slot_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            squash <= 1'b0;
            slot   <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            squash <= squash_nxt;
            slot   <= slot_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc;
        squash_nxt        = squash;
        slot_nxt          = slot;
        line_load         = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        bus.instr_valid   = 1'b0;
        bus.instr         = '0;
        bus.instr_pc      = '0;

        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {pc[ADDRSZ-1:3], 3'b000};
                if (bus.mem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (squash) begin
                        squash_nxt = 1'b0;
                        state_nxt  = S_REQ;
                    end else begin
                        line_load = 1'b1;
                        slot_nxt  = pc[2];
                        state_nxt = S_SEND;
                    end
                end
            end
            S_SEND: begin
                bus.instr_valid = 1'b1;
                bus.instr       = slot_word;
                bus.instr_pc    = pc;
                if (bus.instr_ready) begin
                    pc_nxt = pc + ADDRSZ'(4);
                    if (slot) state_nxt = S_REQ;
                    else      slot_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // A redirect overrides the normal step; an accepted or in-flight line becomes stale.
        if (bus.redirect_valid) begin
            pc_nxt          = {bus.redirect_pc[ADDRSZ-1:2], 2'b00};
            slot_nxt        = 1'b0;
            line_load       = 1'b0;
            bus.instr_valid = 1'b0;
            case (state)
                S_REQ: begin
                    state_nxt  = bus.mem_req_ready ? S_WAIT : S_REQ;
                    squash_nxt = bus.mem_req_ready;
                end
                S_WAIT: begin
                    state_nxt  = bus.mem_resp_valid ? S_REQ : S_WAIT;
                    squash_nxt = !bus.mem_resp_valid;
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with random memory and decoder
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic clk = 1'b0;
    logic reset;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_pc;
    int          checks = 0;
    int          errors = 0;
    int          handshakes = 0;

    // mode: 0 random, 1 held low, 2 held high
    int          mrdy_mode = 1;
    int          irdy_mode = 2;
    int          lat_fixed = 0;
    int          redir_pct = 0;
    int          rst_pm = 0;
    bit          rst_hold = 1'b1;
    bit          rst_cmd = 1'b0;
    bit          redir_cmd = 1'b0;
    logic [63:0] redir_target = '0;

    bit          pend = 1'b0;
    logic [63:0] pend_addr = '0;
    int          pend_lat = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h1000) return 32'h00000013;
        if (a == 64'h1004) return 32'h00500093;
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A1234;
    endfunction

    function automatic void model_restart(input logic [63:0] p);
        exp_q.delete();
        model_pc = {p[63:2], 2'b00};
    endfunction

    function automatic void model_refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{pc: model_pc, word: mem_word(model_pc)});
            model_pc = model_pc + 64'd4;
        end
    endfunction

    function automatic bit pick(input int mode, input int pct);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        if ($urandom_range(3, 0) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
        else                           t = {48'h0, 16'($urandom)};
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // which: 0 instr_valid, 1 mem_req_valid, 2 request accepted
    task automatic wait_for(input int which, input int maxc, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < maxc && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = bus.instr_valid;
                1:       hit = bus.mem_req_valid;
                default: hit = bus.mem_req_valid && bus.mem_req_ready;
            endcase
        end
        if (!hit) timeout(name);
    endtask

    // Driver: memory model, decoder ready, redirects and resets.
    initial begin
        reset              = 1'b1;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        model_restart(RST_PC);
        model_refill();
        forever begin
            @(negedge clk);
            if (!reset && bus.mem_req_valid && bus.mem_req_ready) begin
                chk("one_outstanding", 64'(pend), 64'd0);
                chk("req_align", 64'(bus.mem_req_addr[2:0]), 64'd0);
                pend      = 1'b1;
                pend_addr = bus.mem_req_addr;
                pend_lat  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(3, 0));
            end
            @(posedge clk);
            #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = {$urandom, $urandom};
            bus.redirect_valid = 1'b0;
            reset   = rst_hold || rst_cmd || (rst_pm > 0 && int'($urandom_range(999, 0)) < rst_pm);
            rst_cmd = 1'b0;
            if (reset) begin
                pend = 1'b0;
                model_restart(RST_PC);
            end else begin
                if (pend) begin
                    if (pend_lat == 0) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_resp_data  = {mem_word(pend_addr + 64'd4), mem_word(pend_addr)};
                        pend = 1'b0;
                    end else begin
                        pend_lat--;
                    end
                end
                if (redir_cmd || (redir_pct > 0 && int'($urandom_range(99, 0)) < redir_pct)) begin
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = redir_cmd ? redir_target : rand_target();
                    model_restart(bus.redirect_pc);
                end
                redir_cmd = 1'b0;
            end
            model_refill();
            bus.mem_req_ready = pick(mrdy_mode, 70);
            bus.instr_ready   = pick(irdy_mode, 70);
        end
    end

    // Monitor: every decoder handshake pops the next expected instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.instr_valid && bus.instr_ready) begin
                handshakes++;
                chk("no_req_in_send", 64'(bus.mem_req_valid), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got pc %h with nothing expected", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", bus.instr_pc, e.pc);
                    chk("instr", 64'(bus.instr), 64'(e.word));
                end
            end
        end
    end

    initial begin
        logic [63:0] hold_pc;
        logic [31:0] hold_instr;
        int          hs0;

        repeat (3) @(negedge clk);
        chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_req_addr", bus.mem_req_addr, 64'd0);
        chk("rst_instr", 64'(bus.instr), 64'd0);
        chk("rst_instr_pc", bus.instr_pc, 64'd0);
        rst_hold = 1'b0;

        @(negedge clk);
        chk("idle_no_req", 64'(bus.mem_req_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("req_valid_held", 64'(bus.mem_req_valid), 64'd1);
            chk("req_addr_held", bus.mem_req_addr, 64'h1000);
        end
        mrdy_mode = 2;
        @(negedge clk);
        chk("req_accepted_c4", 64'(bus.mem_req_valid && bus.mem_req_ready), 64'd1);
        chk("req_addr_first", bus.mem_req_addr, 64'h1000);

        irdy_mode = 1;
        wait_for(0, 20, "wait_send1");
        hold_pc    = bus.instr_pc;
        hold_instr = bus.instr;
        chk("first_pc", hold_pc, 64'h1000);
        chk("first_instr", 64'(hold_instr), 64'h13);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(bus.instr_valid), 64'd1);
            chk("stall_instr", 64'(bus.instr), 64'(hold_instr));
            chk("stall_pc", bus.instr_pc, hold_pc);
            chk("stall_no_req", 64'(bus.mem_req_valid), 64'd0);
        end
        irdy_mode = 2;
        wait_for(1, 20, "req_after_line");
        chk("next_line_addr", bus.mem_req_addr, 64'h1008);

        irdy_mode = 1;
        wait_for(0, 40, "wait_send2");
        redir_target = 64'h2004;
        redir_cmd    = 1'b1;
        @(negedge clk);
        chk("redirect_kills_valid", 64'(bus.instr_valid), 64'd0);
        irdy_mode = 2;
        wait_for(1, 20, "req_after_redirect");
        chk("redirect_req_addr", bus.mem_req_addr, 64'h2000);
        wait_for(0, 40, "send_after_redirect");
        chk("redirect_first_pc", bus.instr_pc, 64'h2004);
        chk("redirect_first_instr", 64'(bus.instr), 64'(mem_word(64'h2004)));

        lat_fixed = 2;
        wait_for(2, 40, "accept_for_squash");
        redir_target = 64'h3000;
        redir_cmd    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("squash_no_valid", 64'(bus.instr_valid), 64'd0);
        end
        @(negedge clk);
        chk("squash_req_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("squash_req_addr", bus.mem_req_addr, 64'h3000);

        lat_fixed = 5;
        wait_for(2, 40, "accept_for_reset");
        rst_cmd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("midrst_instr_valid", 64'(bus.instr_valid), 64'd0);
        chk("midrst_req_addr", bus.mem_req_addr, 64'd0);
        chk("midrst_instr", 64'(bus.instr), 64'd0);
        chk("midrst_instr_pc", bus.instr_pc, 64'd0);
        @(negedge clk);
        chk("midrst_restart_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("midrst_restart_addr", bus.mem_req_addr, RST_PC);

        lat_fixed = -1;
        mrdy_mode = 0;
        irdy_mode = 0;
        redir_pct = 3;
        rst_pm    = 3;
        hs0       = handshakes;
        repeat (4000) @(negedge clk);
        redir_pct = 0;
        rst_pm    = 0;
        chk("random_progress", 64'(handshakes - hs0 > 300), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
